// File: rtl/sleep_cycle_controller.sv
// Wake/sleep sequencer for the 8-bit vital energy resource: a tick-paced
// 4-state FSM that issues one-cycle inc/dec/fast/setval commands.
module sleep_cycle_controller #(
  parameter int unsigned DROWSY_THR      = 96,
  parameter int unsigned WAKE_THR        = 224,
  parameter int unsigned DROWSY_TICKS    = 16,
  parameter int unsigned MIN_SLEEP_TICKS = 8,
  parameter int unsigned WAKE_TICKS      = 4,
  parameter int unsigned SET_FLOOR       = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [7:0] vital_energy,
  input  logic       vital_energy_zero,
  input  logic       wake_stimulus,
  output logic       inc,
  output logic       dec,
  output logic       fast,
  output logic       setval,
  output logic       sleeping,
  output logic       drowsy,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    AWAKE  = 2'd0,
    DROWSY = 2'd1,
    ASLEEP = 2'd2,
    WAKING = 2'd3
  } state_t;

  localparam logic [7:0] DROWSY_THR_B  = 8'(DROWSY_THR);
  localparam logic [7:0] WAKE_THR_B    = 8'(WAKE_THR);
  localparam logic [7:0] DROWSY_LAST   = 8'(DROWSY_TICKS - 1);
  localparam logic [7:0] MIN_SLEEP_B   = 8'(MIN_SLEEP_TICKS);
  localparam logic [7:0] WAKE_LAST     = 8'(WAKE_TICKS - 1);
  localparam logic [7:0] SET_FLOOR_B   = 8'(SET_FLOOR);

  state_t     state_q, state_d;
  logic [7:0] drowsy_cnt_q, drowsy_cnt_d;
  logic [7:0] sleep_cnt_q, sleep_cnt_d;
  logic [7:0] wake_cnt_q, wake_cnt_d;
  logic       inc_d, dec_d, fast_d, setval_d;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    drowsy_cnt_d = drowsy_cnt_q;
    sleep_cnt_d  = sleep_cnt_q;
    wake_cnt_d   = wake_cnt_q;
    inc_d        = 1'b0;
    dec_d        = 1'b0;
    fast_d       = 1'b0;
    setval_d     = 1'b0;

    if (tick) begin
      unique case (state_q)
        AWAKE: begin
          dec_d = 1'b1;
          if (vital_energy < DROWSY_THR_B) begin
            state_d      = DROWSY;
            drowsy_cnt_d = 8'd0;
          end
        end
        DROWSY: begin
          dec_d = 1'b1;
          if (vital_energy_zero) begin
            state_d     = ASLEEP;
            sleep_cnt_d = 8'd0;
          end else if (wake_stimulus) begin
            drowsy_cnt_d = 8'd0;
          end else if (drowsy_cnt_q == DROWSY_LAST) begin
            state_d     = ASLEEP;
            sleep_cnt_d = 8'd0;
          end else begin
            drowsy_cnt_d = drowsy_cnt_q + 8'd1;
          end
        end
        ASLEEP: begin
          if (sleep_cnt_q != 8'hFF) sleep_cnt_d = sleep_cnt_q + 8'd1;
          // Forced wake compares the count before this tick's increment.
          if (wake_stimulus && (sleep_cnt_q >= MIN_SLEEP_B)) begin
            state_d    = WAKING;
            wake_cnt_d = 8'd0;
            if (vital_energy < SET_FLOOR_B) setval_d = 1'b1;
            else                            inc_d    = 1'b1;
          end else begin
            inc_d  = 1'b1;
            fast_d = 1'b1;
            if (vital_energy >= WAKE_THR_B) begin
              state_d    = WAKING;
              wake_cnt_d = 8'd0;
            end
          end
        end
        WAKING: begin
          inc_d = 1'b1;
          if (wake_cnt_q == WAKE_LAST) state_d    = AWAKE;
          else                         wake_cnt_d = wake_cnt_q + 8'd1;
        end
        default: state_d = AWAKE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= AWAKE;
      drowsy_cnt_q <= 8'd0;
      sleep_cnt_q  <= 8'd0;
      wake_cnt_q   <= 8'd0;
      inc          <= 1'b0;
      dec          <= 1'b0;
      fast         <= 1'b0;
      setval       <= 1'b0;
      sleeping     <= 1'b0;
      drowsy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      drowsy_cnt_q <= drowsy_cnt_d;
      sleep_cnt_q  <= sleep_cnt_d;
      wake_cnt_q   <= wake_cnt_d;
      inc          <= inc_d;
      dec          <= dec_d;
      fast         <= fast_d;
      setval       <= setval_d;
      sleeping     <= (state_d == ASLEEP);
      drowsy       <= (state_d == DROWSY);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_sleep_cycle_controller.sv
// Directed bench for sleep_cycle_controller: walks every state transition
// with hand-computed command pulses and state values.
module tb_sleep_cycle_controller;

  localparam logic [3:0] C_NONE = 4'b0000;  // {inc,dec,fast,setval}
  localparam logic [3:0] C_DEC  = 4'b0100;
  localparam logic [3:0] C_INC  = 4'b1000;
  localparam logic [3:0] C_INCF = 4'b1010;
  localparam logic [3:0] C_SET  = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] vital_energy = 8'd128;
  logic       vital_energy_zero = 1'b0;
  logic       wake_stimulus = 1'b0;
  logic       inc, dec, fast, setval, sleeping, drowsy;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  sleep_cycle_controller dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .vital_energy(vital_energy), .vital_energy_zero(vital_energy_zero),
    .wake_stimulus(wake_stimulus),
    .inc(inc), .dec(dec), .fast(fast), .setval(setval),
    .sleeping(sleeping), .drowsy(drowsy), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_energy(input logic [7:0] v);
    vital_energy      = v;
    vital_energy_zero = (v == 8'd0);
  endtask

  // One tick: command and status checked 1 cycle later, then one idle cycle
  // to confirm the command pulse lasted exactly one cycle.
  task automatic tick_chk(input string tag, input logic stim,
                          input logic [3:0] exp_cmd, input logic [1:0] exp_st);
    @(negedge clk);
    tick = 1'b1;
    wake_stimulus = stim;
    @(posedge clk);
    #1;
    tick = 1'b0;
    wake_stimulus = 1'b0;
    check({tag, ".cmd"}, {4'd0, inc, dec, fast, setval}, {4'd0, exp_cmd});
    check({tag, ".state"}, {6'd0, state}, {6'd0, exp_st});
    check({tag, ".sleeping"}, {7'd0, sleeping}, {7'd0, exp_st == 2'd2});
    check({tag, ".drowsy"}, {7'd0, drowsy}, {7'd0, exp_st == 2'd1});
    @(posedge clk);
    #1;
    check({tag, ".gap"}, {4'd0, inc, dec, fast, setval}, {4'd0, C_NONE});
    check({tag, ".hold"}, {6'd0, state}, {6'd0, exp_st});
  endtask

  initial begin
    // Reset state
    #12;
    check("rst.cmd", {4'd0, inc, dec, fast, setval}, 8'd0);
    check("rst.state", {6'd0, state}, 8'd0);
    check("rst.status", {6'd0, sleeping, drowsy}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle.cmd", {4'd0, inc, dec, fast, setval}, 8'd0);

    // AWAKE above threshold: plain dec pulses
    for (int i = 0; i < 3; i++) tick_chk("awake", 1'b0, C_DEC, 2'd0);

    // Drop below DROWSY_THR, then natural fall asleep on 16th tick
    set_energy(8'd95);
    tick_chk("to_drowsy", 1'b0, C_DEC, 2'd1);
    for (int i = 0; i < 15; i++) tick_chk("drowsy_wait", 1'b0, C_DEC, 2'd1);
    tick_chk("to_asleep", 1'b0, C_DEC, 2'd2);

    // ASLEEP with low energy: early stimulus ignored, forced wake uses setval
    set_energy(8'd40);
    tick_chk("sleep1", 1'b0, C_INCF, 2'd2);
    tick_chk("sleep2", 1'b0, C_INCF, 2'd2);
    tick_chk("early_stim", 1'b1, C_INCF, 2'd2);
    for (int i = 0; i < 5; i++) tick_chk("sleep_mid", 1'b0, C_INCF, 2'd2);
    tick_chk("forced_set", 1'b1, C_SET, 2'd3);
    tick_chk("waking1", 1'b0, C_INC, 2'd3);
    tick_chk("waking2", 1'b1, C_INC, 2'd3);
    tick_chk("waking3", 1'b0, C_INC, 2'd3);
    tick_chk("to_awake", 1'b0, C_INC, 2'd0);

    // DROWSY stimulus at drowsy_cnt=10 restarts the count
    tick_chk("to_drowsy2", 1'b0, C_DEC, 2'd1);
    for (int i = 0; i < 10; i++) tick_chk("drowsy_pre", 1'b0, C_DEC, 2'd1);
    tick_chk("drowsy_stim", 1'b1, C_DEC, 2'd1);
    for (int i = 0; i < 15; i++) tick_chk("drowsy_post", 1'b0, C_DEC, 2'd1);
    tick_chk("to_asleep2", 1'b0, C_DEC, 2'd2);

    // Natural wake at WAKE_THR boundary
    set_energy(8'd200);
    tick_chk("ramp200", 1'b0, C_INCF, 2'd2);
    set_energy(8'd223);
    tick_chk("ramp223", 1'b0, C_INCF, 2'd2);
    set_energy(8'd224);
    tick_chk("ramp224", 1'b0, C_INCF, 2'd3);
    for (int i = 0; i < 3; i++) tick_chk("waking_n", 1'b0, C_INC, 2'd3);
    tick_chk("to_awake2", 1'b0, C_INC, 2'd0);
    tick_chk("awake224", 1'b0, C_DEC, 2'd0);

    // Zero energy in DROWSY falls asleep at once; forced wake above floor uses inc
    set_energy(8'd50);
    tick_chk("to_drowsy3", 1'b0, C_DEC, 2'd1);
    for (int i = 0; i < 3; i++) tick_chk("drowsy3", 1'b0, C_DEC, 2'd1);
    set_energy(8'd0);
    tick_chk("zero_sleep", 1'b1, C_DEC, 2'd2);
    set_energy(8'd100);
    for (int i = 0; i < 8; i++) tick_chk("sleep100", 1'b0, C_INCF, 2'd2);
    tick_chk("forced_inc", 1'b1, C_INC, 2'd3);
    for (int i = 0; i < 3; i++) tick_chk("waking_f", 1'b0, C_INC, 2'd3);
    tick_chk("to_awake3", 1'b0, C_INC, 2'd0);

    // Reset while ASLEEP with a tick pending
    set_energy(8'd50);
    tick_chk("to_drowsy4", 1'b0, C_DEC, 2'd1);
    set_energy(8'd0);
    tick_chk("zero_sleep2", 1'b0, C_DEC, 2'd2);
    set_energy(8'd100);
    @(negedge clk);
    tick = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst.state", {6'd0, state}, 8'd0);
    check("mid_rst.status", {6'd0, sleeping, drowsy}, 8'd0);
    check("mid_rst.cmd", {4'd0, inc, dec, fast, setval}, 8'd0);
    @(negedge clk);
    tick = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_rst.cmd", {4'd0, inc, dec, fast, setval}, 8'd0);
      check("post_rst.state", {6'd0, state}, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
